// File: rtl/expr_ctrl_pkg.sv
// Shared types for the expression-recognizer share controller: FSM states, requester count,
// and the ASCII codes of the expression alphabet.
package expr_ctrl_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_WAIT   = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

   localparam logic [7:0] ASC_0    = 8'd48;
   localparam logic [7:0] ASC_9    = 8'd57;
   localparam logic [7:0] ASC_PLUS = 8'd43;
   localparam logic [7:0] ASC_STAR = 8'd42;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational: a lone request wins outright,
// a tie goes to the requester named by ptr_i.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic       gnt_o,
   output logic       any_o
);

   always_comb begin
      any_o = |req_i;
      unique case (req_i)
         2'b10:   gnt_o = 1'b1;
         2'b11:   gnt_o = ptr_i;
         default: gnt_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/expr_share_ctrl.sv
// Shares one recognizer between two char streams: arbitrate, clear, stream one string, report.
// Result pulses 2 cycles after the last char; the ungranted requester sees req_ready low.
module expr_share_ctrl
   import expr_ctrl_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_char,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 fsm_clr,
   output logic [7:0]           fsm_in,
   input  logic                 fsm_out,
   output logic                 res_valid,
   output logic                 res_id,
   output logic                 res_match,
   output logic                 res_err,
   output logic [LEN_W-1:0]     res_len,
   output logic                 busy
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   state_t             state_q, state_d;
   logic               gnt_q, gnt_d;
   logic               rr_q, rr_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               res_vld_q, res_vld_d;
   logic               res_id_q, res_id_d;
   logic               res_match_q, res_match_d;
   logic               res_err_q, res_err_d;
   logic [LEN_W-1:0]   res_len_q, res_len_d;
   logic [NUM_REQ-1:0] ready_q;
   logic               fsm_clr_q;
   logic               busy_q;

   logic               arb_gnt, arb_any;
   logic               vld_g, last_g;
   logic [7:0]         char_g;

   rr_arb2 u_arb (
      .req_i (req_valid),
      .ptr_i (rr_q),
      .gnt_o (arb_gnt),
      .any_o (arb_any)
   );

   assign vld_g   = req_valid[gnt_q];
   assign last_g  = req_last[gnt_q];
   assign char_g  = gnt_q ? req_char[15:8] : req_char[7:0];
   assign cnt_inc = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + LEN_W'(1);

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      res_vld_d   = 1'b0;
      res_id_d    = res_id_q;
      res_match_d = res_match_q;
      res_err_d   = res_err_q;
      res_len_d   = res_len_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               gnt_d   = arb_gnt;
               cnt_d   = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: state_d = ST_STREAM;
         ST_STREAM: begin
            if (vld_g) begin
               cnt_d = cnt_inc;
               if (last_g) begin
                  state_d = ST_WAIT;
               end else if (cnt_inc == LEN_MAX) begin
                  state_d     = ST_REPORT;
                  res_vld_d   = 1'b1;
                  res_id_d    = gnt_q;
                  res_len_d   = cnt_inc;
                  res_err_d   = 1'b1;
                  res_match_d = 1'b0;
               end
            end else begin
               // Requester broke a contiguous stream: abort without consuming a char.
               state_d     = ST_REPORT;
               res_vld_d   = 1'b1;
               res_id_d    = gnt_q;
               res_len_d   = cnt_q;
               res_err_d   = 1'b1;
               res_match_d = 1'b0;
            end
         end
         ST_WAIT: begin
            state_d     = ST_REPORT;
            res_vld_d   = 1'b1;
            res_id_d    = gnt_q;
            res_len_d   = cnt_q;
            res_err_d   = 1'b0;
            res_match_d = fsm_out;
         end
         ST_REPORT: begin
            rr_d    = ~gnt_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q     <= ST_IDLE;
         gnt_q       <= 1'b0;
         rr_q        <= 1'b0;
         cnt_q       <= '0;
         res_vld_q   <= 1'b0;
         res_id_q    <= 1'b0;
         res_match_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_len_q   <= '0;
         ready_q     <= '0;
         fsm_clr_q   <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         res_vld_q   <= res_vld_d;
         res_id_q    <= res_id_d;
         res_match_q <= res_match_d;
         res_err_q   <= res_err_d;
         res_len_q   <= res_len_d;
         // Outputs follow the state being entered so they are clean registers.
         ready_q     <= (state_d == ST_STREAM) ? {gnt_d, ~gnt_d} : '0;
         fsm_clr_q   <= (state_d != ST_STREAM) && (state_d != ST_WAIT);
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign req_ready = ready_q;
   assign fsm_clr   = fsm_clr_q;
   assign fsm_in    = (state_q == ST_STREAM) ? char_g : 8'h00;
   assign busy      = busy_q;
   assign res_valid = res_vld_q;
   assign res_id    = res_id_q;
   assign res_match = res_match_q;
   assign res_err   = res_err_q;
   assign res_len   = res_len_q;

endmodule

// File: tb/tb_expr_share_ctrl.sv
// Scoreboarded bench: per-requester drivers push expected results, a monitor pops on res_valid.
module tb_expr_share_ctrl;
   import expr_ctrl_pkg::*;

   localparam int M_NORM = 0;
   localparam int M_DROP = 1;
   localparam int M_MAX  = 2;

   typedef struct {
      bit match;
      bit err;
      int len;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [1:0]  req_valid, req_last, req_ready;
   logic [15:0] req_char;
   logic        fsm_clr, fsm_out, res_valid, res_id, res_match, res_err, busy;
   logic [7:0]  fsm_in;
   logic [4:0]  res_len;

   logic        vld[2];
   logic [7:0]  chr[2];
   logic        lst[2];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   first_acc[2];
   exp_t exp_q[2][$];
   int   got_ids[$];
   int   rs = 0;

   assign req_valid = {vld[1], vld[0]};
   assign req_char  = {chr[1], chr[0]};
   assign req_last  = {lst[1], lst[0]};

   expr_share_ctrl #(.MAX_LEN(16), .LEN_W(5)) dut (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_char(req_char), .req_last(req_last),
      .req_ready(req_ready), .fsm_clr(fsm_clr), .fsm_in(fsm_in), .fsm_out(fsm_out),
      .res_valid(res_valid), .res_id(res_id), .res_match(res_match), .res_err(res_err),
      .res_len(res_len), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in recognizer for digit(op digit)*: 0 start, 1 after digit, 2 after op, 3 dead.
   function automatic bit is_dig(input logic [7:0] c);
      return (c >= ASC_0) && (c <= ASC_9);
   endfunction
   function automatic bit is_op(input logic [7:0] c);
      return (c == ASC_PLUS) || (c == ASC_STAR);
   endfunction
   always @(posedge clk) begin
      if (fsm_clr) rs <= 0;
      else case (rs)
         0, 2:    rs <= is_dig(fsm_in) ? 1 : 3;
         1:       rs <= is_op(fsm_in) ? 2 : 3;
         default: rs <= 3;
      endcase
   end
   assign fsm_out = (rs == 1);

   // Reference verdict on the whole string: odd length, digits at even slots, ops at odd.
   function automatic bit is_expr(input logic [127:0] s, input int n);
      if (n % 2 == 0) return 1'b0;
      for (int k = 0; k < n; k++) begin
         if (k % 2 == 0 && !is_dig(s[8*k +: 8])) return 1'b0;
         if (k % 2 == 1 && !is_op(s[8*k +: 8])) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [127:0] mk(input string str);
      logic [127:0] s;
      s = '0;
      for (int k = 0; k < str.len(); k++) s[8*k +: 8] = str[k];
      return s;
   endfunction

   function automatic logic [127:0] gen(input int n, input bit corrupt);
      logic [127:0] s;
      int pos;
      s = '0;
      for (int k = 0; k < n; k++) begin
         if (k % 2 == 0) s[8*k +: 8] = ASC_0 + 8'($urandom_range(9));
         else            s[8*k +: 8] = ($urandom_range(1) == 1) ? ASC_PLUS : ASC_STAR;
      end
      if (corrupt) begin
         pos = $urandom_range(n - 1);
         case ($urandom_range(3))
            0:       s[8*pos +: 8] = 8'd97;
            1:       s[8*pos +: 8] = ASC_PLUS;
            2:       s[8*pos +: 8] = ASC_0 + 8'd3;
            default: s[8*pos +: 8] = 8'd32;
         endcase
      end
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (clr && res_valid) begin
         got_ids.push_back(int'(res_id));
         if (exp_q[res_id].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: id=%0d len=%0d, required no result", res_id, res_len);
         end else begin
            e = exp_q[res_id].pop_front();
            chk("res_match", 32'(res_match), 32'(e.match));
            chk("res_err",   32'(res_err),   32'(e.err));
            chk("res_len",   32'(res_len),   32'(e.len));
            chk("res_cycle", 32'(cyc),       32'(e.cyc));
         end
      end
   end

   // Drives one string on requester id; the expectation is queued at the final handshake.
   task automatic send(input int id, input int n, input int mode, input logic [127:0] s);
      int   w;
      bit   ok;
      exp_t e;
      ok = 1'b1;
      for (int k = 0; k < n && ok; k++) begin
         vld[id] = 1'b1;
         chr[id] = s[8*k +: 8];
         lst[id] = (mode == M_NORM) && (k == n - 1);
         w = 0;
         while (!req_ready[id] && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (!req_ready[id]) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: id=%0d ready=0, required 1", id);
            ok = 1'b0;
         end else begin
            if (k == 0) first_acc[id] = cyc;
            if (k == n - 1) begin
               e.match = (mode == M_NORM) ? is_expr(s, n) : 1'b0;
               e.err   = (mode != M_NORM);
               e.len   = n;
               e.cyc   = (mode == M_MAX) ? cyc + 1 : cyc + 2;
               exp_q[id].push_back(e);
            end
            @(negedge clk);
            if (k == n - 1 && mode == M_MAX) chk("ready_after_max", 32'(req_ready[id]), 32'd0);
         end
      end
      vld[id] = 1'b0;
      lst[id] = 1'b0;
      chr[id] = 8'd0;
      @(negedge clk);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((exp_q[0].size() + exp_q[1].size()) != 0 && w < 60) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic rand_one(input int id);
      int m, n, mode;
      m = $urandom_range(9);
      if (m == 0)      begin mode = M_DROP; n = $urandom_range(15, 1); end
      else if (m == 1) begin mode = M_MAX;  n = 16; end
      else             begin mode = M_NORM; n = $urandom_range(16, 1); end
      send(id, n, mode, gen(n, $urandom_range(3) == 0));
      repeat ($urandom_range(3)) @(negedge clk);
   endtask

   initial begin
      int start;
      for (int i = 0; i < 2; i++) begin
         vld[i] = 1'b0; chr[i] = 8'd0; lst[i] = 1'b0; first_acc[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_fsm_clr",   32'(fsm_clr),   32'd1);
      chk("rst_fsm_in",    32'(fsm_in),    32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_id",    32'(res_id),    32'd0);
      chk("rst_res_match", 32'(res_match), 32'd0);
      chk("rst_res_err",   32'(res_err),   32'd0);
      chk("rst_res_len",   32'(res_len),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      clr = 1'b1;
      @(negedge clk);

      // Tie straight after reset goes to req0, then req1; next tie (after req1) to req0.
      got_ids.delete();
      fork
         send(0, 3, M_NORM, mk("1+2"));
         send(1, 3, M_NORM, mk("3*4"));
      join
      drain();
      chk("tie1_first",  32'(got_ids[0]), 32'd0);
      chk("tie1_second", 32'(got_ids[1]), 32'd1);
      got_ids.delete();
      fork
         send(0, 1, M_NORM, mk("9"));
         send(1, 2, M_NORM, mk("1+"));
      join
      drain();
      chk("tie2_first", 32'(got_ids[0]), 32'd0);

      // Lone req0 "1+2" from idle: first char accepted two cycles after valid is seen.
      start = cyc;
      send(0, 3, M_NORM, mk("1+2"));
      drain();
      chk("grant_latency", 32'(first_acc[0] - start), 32'd2);

      // Req0 was served last, so a tie now goes to req1.
      got_ids.delete();
      fork
         send(0, 2, M_NORM, mk("5*"));
         send(1, 1, M_NORM, mk("8"));
      join
      drain();
      chk("tie3_first", 32'(got_ids[0]), 32'd1);

      // Req1 "1+": recognizer held in clear for one cycle, then fed the granted char.
      fork
         send(1, 2, M_NORM, mk("1+"));
         begin
            @(negedge clk);
            chk("clear_fsm_clr",   32'(fsm_clr),   32'd1);
            chk("clear_req_ready", 32'(req_ready), 32'd0);
            chk("clear_busy",      32'(busy),      32'd1);
            @(negedge clk);
            chk("stream_fsm_clr",   32'(fsm_clr),   32'd0);
            chk("stream_req_ready", 32'(req_ready), 32'd2);
            chk("stream_fsm_in",    32'(fsm_in),    32'd49);
         end
      join
      drain();

      // Abort by dropping valid, then a clean string; then an over-length stream.
      send(0, 2, M_DROP, mk("2*"));
      send(0, 1, M_NORM, mk("7"));
      drain();
      send(1, 16, M_MAX, mk("1+1+1+1+1+1+1+1+"));
      drain();

      // Reset while streaming: back to idle with reset outputs and no result.
      vld[0] = 1'b1; chr[0] = 8'd53; lst[0] = 1'b0;
      start = 0;
      while (!req_ready[0] && start < 20) begin
         @(negedge clk);
         start++;
      end
      chk("mid_reset_streaming", 32'(req_ready[0]), 32'd1);
      clr = 1'b0;
      @(negedge clk);
      chk("mid_reset_busy",      32'(busy),      32'd0);
      chk("mid_reset_req_ready", 32'(req_ready), 32'd0);
      chk("mid_reset_fsm_clr",   32'(fsm_clr),   32'd1);
      chk("mid_reset_fsm_in",    32'(fsm_in),    32'd0);
      chk("mid_reset_res_valid", 32'(res_valid), 32'd0);
      vld[0] = 1'b0; chr[0] = 8'd0;
      clr = 1'b1;
      repeat (4) @(negedge clk);

      fork
         begin for (int i = 0; i < 25; i++) rand_one(0); end
         begin for (int i = 0; i < 25; i++) rand_one(1); end
      join
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
